hwpe_ctrl_ctx_scheduler: RTL and testbench

//  Job-context scheduler between the HWPE slave register file and the engine datapath.
//  - Allocates up to N_CONTEXT job contexts to offloading cores (acquire), in ring order.
//  - Launches triggered contexts one at a time (start pulse), waits for engine done.
//  - Returns a per-core completion event and keeps a finished-job counter.

---
 rtl/hwpe_ctrl_ctx_scheduler.sv | 162 ++++++++++++++++
 tb/tb_hwpe_ctrl_ctx_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_ctx_scheduler.sv
// Job-context scheduler: allocates ring-ordered job contexts to cores, launches them
// one at a time on the engine and signals completion. Optional watchdog: HWPE_CTRL_SCHED_TIMEOUT_EN.
module hwpe_ctrl_ctx_scheduler #(
    parameter int unsigned N_CONTEXT      = 2,
    parameter int unsigned N_CORES        = 16,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         acquire_req_i,
    input  logic [$clog2(N_CORES)-1:0]   acquire_core_i,
    output logic                         acquire_gnt_o,
    output logic [$clog2(N_CONTEXT)-1:0] acquire_id_o,
    input  logic                         trigger_i,
    input  logic [$clog2(N_CONTEXT)-1:0] trigger_id_i,
    output logic                         start_o,
    output logic [$clog2(N_CONTEXT)-1:0] running_id_o,
    input  logic                         done_i,
    output logic [N_CORES-1:0]           evt_o,
    output logic                         err_o,
    output logic                         full_o,
    output logic                         busy_o,
    output logic [CNT_W-1:0]             nb_finished_o
);
    localparam int IW = $clog2(N_CONTEXT);
    localparam int CW = $clog2(N_CORES);

    typedef enum logic [1:0] {SL_FREE, SL_ACQ, SL_READY, SL_RUN} slot_e;
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN, ST_NOTIFY} state_e;

    slot_e            slot_q  [N_CONTEXT];
    slot_e            slot_d  [N_CONTEXT];
    logic [CW-1:0]    owner_q [N_CONTEXT];
    logic [CW-1:0]    owner_d [N_CONTEXT];
    logic [IW-1:0]    acq_ptr_q, acq_ptr_d;
    logic [IW-1:0]    run_ptr_q, run_ptr_d;
    logic [IW-1:0]    running_id_q, running_id_d;
    logic [CNT_W-1:0] nb_q, nb_d;
    logic             full_q, full_d;
    state_e           state_q, state_d;
    logic             any_used;

`ifdef HWPE_CTRL_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
    assign err_o = (state_q == ST_NOTIFY) & err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign err_o = 1'b0;
`endif

    // Gated by reset so no grant is reported while the state is being cleared.
    assign acquire_gnt_o = acquire_req_i & ~full_q & ~rst_i;
    assign acquire_id_o  = acq_ptr_q;
    assign start_o       = (state_q == ST_START);
    assign evt_o         = (state_q == ST_NOTIFY) ? (N_CORES'(1) << owner_q[run_ptr_q]) : '0;
    assign full_o        = full_q;
    assign busy_o        = any_used | (state_q != ST_IDLE);
    assign running_id_o  = running_id_q;
    assign nb_finished_o = nb_q;

    always_comb begin
        any_used = 1'b0;
        for (int i = 0; i < int'(N_CONTEXT); i++)
            if (slot_q[i] != SL_FREE) any_used = 1'b1;
    end

    always_comb begin
        slot_d       = slot_q;
        owner_d      = owner_q;
        acq_ptr_d    = acq_ptr_q;
        run_ptr_d    = run_ptr_q;
        running_id_d = running_id_q;
        nb_d         = nb_q;
        state_d      = state_q;
`ifdef HWPE_CTRL_SCHED_TIMEOUT_EN
        tcnt_d       = tcnt_q;
        err_d        = err_q;
`endif
        if (acquire_gnt_o) begin
            slot_d[acq_ptr_q]  = SL_ACQ;
            owner_d[acq_ptr_q] = acquire_core_i;
            acq_ptr_d          = acq_ptr_q + IW'(1);
        end
        // Only a committed-but-not-triggered context may become READY.
        if (trigger_i && slot_q[trigger_id_i] == SL_ACQ)
            slot_d[trigger_id_i] = SL_READY;

        case (state_q)
            ST_IDLE: if (slot_q[run_ptr_q] == SL_READY) state_d = ST_START;
            ST_START: begin
                slot_d[run_ptr_q] = SL_RUN;
                running_id_d      = run_ptr_q;
                state_d           = ST_RUN;
`ifdef HWPE_CTRL_SCHED_TIMEOUT_EN
                tcnt_d            = '0;
`endif
            end
            ST_RUN: begin
`ifdef HWPE_CTRL_SCHED_TIMEOUT_EN
                if (done_i) begin
                    state_d = ST_NOTIFY;
                    err_d   = 1'b0;
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_NOTIFY;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d  = tcnt_q + TW'(1);
                end
`else
                if (done_i) state_d = ST_NOTIFY;
`endif
            end
            ST_NOTIFY: begin
                slot_d[run_ptr_q] = SL_FREE;
                run_ptr_d         = run_ptr_q + IW'(1);
                nb_d              = nb_q + CNT_W'(1);
                state_d           = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        full_d = 1'b1;
        for (int i = 0; i < int'(N_CONTEXT); i++)
            if (slot_d[i] == SL_FREE) full_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(N_CONTEXT); i++) begin
                slot_q[i]  <= SL_FREE;
                owner_q[i] <= '0;
            end
            acq_ptr_q    <= '0;
            run_ptr_q    <= '0;
            running_id_q <= '0;
            nb_q         <= '0;
            full_q       <= 1'b0;
            state_q      <= ST_IDLE;
`ifdef HWPE_CTRL_SCHED_TIMEOUT_EN
            tcnt_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            slot_q       <= slot_d;
            owner_q      <= owner_d;
            acq_ptr_q    <= acq_ptr_d;
            run_ptr_q    <= run_ptr_d;
            running_id_q <= running_id_d;
            nb_q         <= nb_d;
            full_q       <= full_d;
            state_q      <= state_d;
`ifdef HWPE_CTRL_SCHED_TIMEOUT_EN
            tcnt_q       <= tcnt_d;
            err_q        <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_hwpe_ctrl_ctx_scheduler.sv
// Randomized + directed bench for hwpe_ctrl_ctx_scheduler against a timestamp-based job model.
module tb_hwpe_ctrl_ctx_scheduler;
    localparam int NC = 2;
    localparam int NCORE = 16;
    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        acquire_req_i = 1'b0;
    logic [3:0]  acquire_core_i = '0;
    logic        acquire_gnt_o;
    logic [0:0]  acquire_id_o;
    logic        trigger_i = 1'b0;
    logic [0:0]  trigger_id_i = '0;
    logic        start_o;
    logic [0:0]  running_id_o;
    logic        done_i = 1'b0;
    logic [15:0] evt_o;
    logic        err_o;
    logic        full_o;
    logic        busy_o;
    logic [7:0]  nb_finished_o;

    int checks = 0;
    int errors = 0;

    hwpe_ctrl_ctx_scheduler #(.N_CONTEXT(NC), .N_CORES(NCORE), .CNT_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .acquire_req_i(acquire_req_i), .acquire_core_i(acquire_core_i),
        .acquire_gnt_o(acquire_gnt_o), .acquire_id_o(acquire_id_o),
        .trigger_i(trigger_i), .trigger_id_i(trigger_id_i),
        .start_o(start_o), .running_id_o(running_id_o), .done_i(done_i),
        .evt_o(evt_o), .err_o(err_o), .full_o(full_o), .busy_o(busy_o),
        .nb_finished_o(nb_finished_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: slot states (0 free,1 acquired,2 ready,3 running) plus event timestamps.
    int ms[NC], mown[NC], rdy_t[NC];
    int acq_p, run_p, active, st_t, evt_at, evt_err, idle_from, run_id, nb, cyc;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin ms[i] = 0; mown[i] = 0; rdy_t[i] = 0; end
        acq_p = 0; run_p = 0; active = 0; st_t = 0; evt_at = -1; evt_err = 0;
        idle_from = cyc + 1; run_id = 0; nb = 0;
    endtask

    always @(negedge clk_i) begin
        int old[NC];
        int efull, ebusy, egnt, estart;
        logic [15:0] eevt;
        cyc++;
        if (rst_i) begin
            model_reset();
        end else begin
            efull = 1; ebusy = 0;
            for (int i = 0; i < NC; i++) begin
                if (ms[i] == 0) efull = 0; else ebusy = 1;
                old[i] = ms[i];
            end
            egnt   = (acquire_req_i && !efull) ? 1 : 0;
            estart = (!active && ms[run_p] == 2 && rdy_t[run_p] <= cyc - 1 && idle_from <= cyc - 1) ? 1 : 0;
            eevt   = (evt_at == cyc) ? (16'h1 << mown[run_p]) : 16'h0;
            chk("m_gnt", acquire_gnt_o, egnt);
            chk("m_acq_id", acquire_id_o, acq_p);
            chk("m_start", start_o, estart);
            chk("m_running_id", running_id_o, run_id);
            chk("m_evt", evt_o, eevt);
            chk("m_err", err_o, (evt_at == cyc) ? evt_err : 0);
            chk("m_full", full_o, efull);
            chk("m_busy", busy_o, ebusy);
            chk("m_nb", nb_finished_o, nb);
            if (egnt) begin
                ms[acq_p] = 1; mown[acq_p] = acquire_core_i; acq_p = (acq_p + 1) % NC;
            end
            if (trigger_i && old[trigger_id_i] == 1) begin
                ms[trigger_id_i] = 2; rdy_t[trigger_id_i] = cyc + 1;
            end
            if (estart) begin
                ms[run_p] = 3; active = 1; st_t = cyc; run_id = run_p;
            end
            if (active && evt_at < 0 && cyc >= st_t + 1) begin
                if (done_i) begin evt_at = cyc + 1; evt_err = 0; end
`ifdef HWPE_CTRL_SCHED_TIMEOUT_EN
                else if (cyc == st_t + TO) begin evt_at = cyc + 1; evt_err = 1; end
`endif
            end
            if (eevt != 0) begin
                ms[run_p] = 0; run_p = (run_p + 1) % NC; active = 0; evt_at = -1;
                nb = (nb + 1) % 256; idle_from = cyc + 1;
            end
        end
    end

    task automatic step(); @(posedge clk_i); #1; endtask
    task automatic clr_in();
        acquire_req_i = 0; trigger_i = 0; done_i = 0;
    endtask
    task automatic do_reset();
        clr_in(); rst_i = 1; step(); step(); rst_i = 0;
    endtask

    initial begin
        cyc = 0;
        // Single job end-to-end from core 3
        do_reset();
        acquire_req_i = 1; acquire_core_i = 3;
        @(negedge clk_i); chk("t1_gnt", acquire_gnt_o, 1); chk("t1_id", acquire_id_o, 0);
        step(); acquire_req_i = 0; trigger_i = 1; trigger_id_i = 0;
        @(negedge clk_i); chk("t1_start_t", start_o, 0);
        step(); trigger_i = 0;
        @(negedge clk_i); chk("t1_start_t1", start_o, 0);
        step(); @(negedge clk_i); chk("t1_start_t2", start_o, 1);
        step(); done_i = 1;
        @(negedge clk_i); chk("t1_running_id", running_id_o, 0);
        step(); done_i = 0;
        @(negedge clk_i); chk("t1_evt", evt_o, 16'h0008); chk("t1_nb_before", nb_finished_o, 0);
        step(); @(negedge clk_i); chk("t1_nb", nb_finished_o, 1); chk("t1_evt_gone", evt_o, 0);

        // Full ring, slot reusable only the cycle after NOTIFY
        do_reset();
        acquire_req_i = 1; acquire_core_i = 1;
        @(negedge clk_i); chk("t2_gnt0", acquire_gnt_o, 1);
        step(); acquire_core_i = 2;
        @(negedge clk_i); chk("t2_gnt1", acquire_gnt_o, 1); chk("t2_id1", acquire_id_o, 1);
        step(); acquire_core_i = 5;
        @(negedge clk_i); chk("t2_gnt_full", acquire_gnt_o, 0); chk("t2_full", full_o, 1);
        step(); acquire_req_i = 0; trigger_i = 1; trigger_id_i = 0;
        step(); trigger_i = 0;
        step(); step(); done_i = 1;
        step(); done_i = 0; acquire_req_i = 1; acquire_core_i = 7;
        @(negedge clk_i); chk("t2_evt", evt_o, 16'h0002); chk("t2_gnt_notify", acquire_gnt_o, 0);
        step(); @(negedge clk_i); chk("t2_gnt_after", acquire_gnt_o, 1); chk("t2_id_after", acquire_id_o, 0);
        step(); clr_in();

        // Strict ring order
        do_reset();
        acquire_req_i = 1; acquire_core_i = 4; step();
        acquire_core_i = 6; step();
        acquire_req_i = 0; trigger_i = 1; trigger_id_i = 1; step();
        trigger_i = 0;
        repeat (4) begin @(negedge clk_i); chk("t3_wait", start_o, 0); step(); end
        trigger_i = 1; trigger_id_i = 0; step();
        trigger_i = 0; step();
        @(negedge clk_i); chk("t3_start0", start_o, 1);
        step(); done_i = 1;
        step(); done_i = 0;
        @(negedge clk_i); chk("t3_evt0", evt_o, 16'h0010);
        step(); @(negedge clk_i); chk("t3_d2", start_o, 0);
        step(); @(negedge clk_i); chk("t3_d3", start_o, 1);
        step(); @(negedge clk_i); chk("t3_rid1", running_id_o, 1);
        done_i = 1; step(); done_i = 0;
        @(negedge clk_i); chk("t3_evt1", evt_o, 16'h0040);
        step();

        // Spurious trigger and done
        do_reset();
        trigger_i = 1; trigger_id_i = 0; done_i = 1; step();
        trigger_id_i = 1; step(); clr_in();
        repeat (3) begin
            @(negedge clk_i); chk("t4_start", start_o, 0); chk("t4_evt", evt_o, 0); chk("t4_nb", nb_finished_o, 0);
            step();
        end

        // Reset while running
        do_reset();
        acquire_req_i = 1; acquire_core_i = 2; step();
        acquire_req_i = 0; trigger_i = 1; trigger_id_i = 0; step();
        trigger_i = 0; step(); step();
        rst_i = 1; step(); rst_i = 0;
        @(negedge clk_i);
        chk("t5_busy", busy_o, 0); chk("t5_full", full_o, 0); chk("t5_start", start_o, 0);
        chk("t5_nb", nb_finished_o, 0); chk("t5_rid", running_id_o, 0);
        done_i = 1; step(); done_i = 0;
        @(negedge clk_i); chk("t5_evt", evt_o, 0); chk("t5_busy2", busy_o, 0);
        step();

`ifdef HWPE_CTRL_SCHED_TIMEOUT_EN
        do_reset();
        acquire_req_i = 1; acquire_core_i = 9; step();
        acquire_req_i = 0; trigger_i = 1; trigger_id_i = 0; step();
        trigger_i = 0; step();
        @(negedge clk_i); chk("to_start", start_o, 1);
        step();
        repeat (TO) step();
        @(negedge clk_i); chk("to_evt", evt_o, 16'h0200); chk("to_err", err_o, 1);
        step(); @(negedge clk_i); chk("to_busy", busy_o, 0);
`endif

        // Random traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            acquire_req_i  = ($urandom_range(0, 2) == 0);
            acquire_core_i = 4'($urandom_range(0, 15));
            trigger_i      = ($urandom_range(0, 2) == 0);
            trigger_id_i   = 1'($urandom_range(0, 1));
            done_i         = ($urandom_range(0, 7) == 0);
            rst_i          = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst_i = 0; clr_in(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
